// File: rtl/seq_mult_hs_if.sv
// Operand/result handshake bundle for seq_mult_hs: valid/ready on the operand
// side, valid/ready on the product side, plus a busy status flag.
interface seq_mult_hs_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 is_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 busy;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/seq_mult_hs.sv
// Sequential shift-add multiplier retiring STEP multiplier bits per cycle,
// signed or unsigned per operation, with valid/ready on both sides.
module seq_mult_hs #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    seq_mult_hs_if.slave  bus
);
    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_next;
    logic [PW-1:0]      mcand_sh;
    logic [WIDTH-1:0]   mplr;
    logic [PW-1:0]      acc;
    logic [PW-1:0]      acc_next;
    logic [PW-1:0]      result_r;
    logic [CW-1:0]      cnt;
    logic               neg;
    logic               last;

    // Two's complement magnitude; the most negative value maps to 2^(WIDTH-1),
    // which still fits the unsigned WIDTH-bit field.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v,
                                                 input logic n);
        return n ? -v : v;
    endfunction

    // The multiplicand is kept pre-shifted so each step adds an aligned partial product.
    assign acc_next = acc + PW'(mplr[STEP-1:0]) * mcand_sh;
    assign last     = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.in_valid) state_next = CALC;
            CALC: if (last)         state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mcand_sh <= '0;
            mplr     <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            result_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand_sh <= PW'(magnitude(bus.a, bus.is_signed));
                        mplr     <= magnitude(bus.b, bus.is_signed);
                        neg      <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        acc      <= '0;
                        cnt      <= '0;
                    end
                end
                CALC: begin
                    acc      <= acc_next;
                    mplr     <= mplr >> STEP;
                    mcand_sh <= mcand_sh << STEP;
                    cnt      <= cnt + CW'(1);
                    if (last) result_r <= apply_sign(acc_next, neg);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = result_r;
endmodule

// File: tb/tb_seq_mult_hs.sv
// Directed bench for seq_mult_hs: one STEP=1 and one STEP=4 instance, WIDTH=8.
module tb_seq_mult_hs;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_mult_hs_if #(.WIDTH(8)) m1();
    seq_mult_hs_if #(.WIDTH(8)) m4();

    seq_mult_hs #(.WIDTH(8), .STEP(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(m1.slave));
    seq_mult_hs #(.WIDTH(8), .STEP(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(m4.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic s);
        if (sel) begin m4.in_valid = v; m4.a = a; m4.b = b; m4.is_signed = s; end
        else     begin m1.in_valid = v; m1.a = a; m1.b = b; m1.is_signed = s; end
    endtask

    task automatic set_ordy(input bit sel, input logic r);
        if (sel) m4.out_ready = r;
        else     m1.out_ready = r;
    endtask

    function automatic logic get_ov(input bit sel);
        return sel ? m4.out_valid : m1.out_valid;
    endfunction

    function automatic logic get_ir(input bit sel);
        return sel ? m4.in_ready : m1.in_ready;
    endfunction

    function automatic logic get_busy(input bit sel);
        return sel ? m4.busy : m1.busy;
    endfunction

    function automatic logic [15:0] get_res(input bit sel);
        return sel ? m4.result : m1.result;
    endfunction

    // Present operands for one edge, then scramble them to show they are ignored.
    task automatic start_op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                            input logic s);
        drive(sel, 1'b1, a, b, s);
        tick();
        drive(sel, 1'b0, ~a, ~b, ~s);
    endtask

    task automatic wait_done(input bit sel, input string tag, input int lat);
        int n = 0;
        while (!get_ov(sel) && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, lat);
    endtask

    task automatic finish_op(input bit sel, input string tag);
        set_ordy(sel, 1'b1);
        tick();
        set_ordy(sel, 1'b0);
        chk({tag, "_idle_ir"}, get_ir(sel), 1'b1);
        chk({tag, "_idle_ov"}, get_ov(sel), 1'b0);
    endtask

    task automatic op(input bit sel, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic [15:0] exp, input string tag);
        start_op(sel, a, b, s);
        chk({tag, "_busy"}, get_busy(sel), 1'b1);
        wait_done(sel, tag, sel ? 2 : 8);
        chk({tag, "_res"}, get_res(sel), exp);
        finish_op(sel, tag);
    endtask

    task automatic rand_op(input bit sel, input string tag);
        logic [7:0]  a, b;
        logic        s;
        int          sa, sb;
        logic [31:0] p;
        a  = 8'($urandom_range(0, 255));
        b  = 8'($urandom_range(0, 255));
        s  = 1'($urandom_range(0, 1));
        sa = s ? int'($signed(a)) : int'(a);
        sb = s ? int'($signed(b)) : int'(b);
        p  = sa * sb;
        start_op(sel, a, b, s);
        wait_done(sel, tag, sel ? 2 : 8);
        chk({tag, "_res"}, get_res(sel), p[15:0]);
        set_ordy(sel, 1'b1);
        tick();
        set_ordy(sel, 1'b0);
    endtask

    logic [15:0] held;

    initial begin
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        set_ordy(1'b0, 1'b0);
        set_ordy(1'b1, 1'b0);
        tick();
        tick();
        chk("rst_ov", m1.out_valid, 1'b0);
        chk("rst_ir", m1.in_ready, 1'b1);
        chk("rst_busy", m1.busy, 1'b0);
        chk("rst_res", m1.result, 16'h0000);
        chk("rst4_res", m4.result, 16'h0000);
        reset_n = 1'b1;
        tick();

        op(1'b0, 8'd200, 8'd250, 1'b0, 16'hC350, "u200x250");
        op(1'b0, 8'h80, 8'h80, 1'b1, 16'h4000, "sm128xm128");
        op(1'b0, 8'h80, 8'h7F, 1'b1, 16'hC080, "sm128x127");
        op(1'b0, 8'h00, 8'hFB, 1'b1, 16'h0000, "s0xm5");
        op(1'b0, 8'hFF, 8'h01, 1'b1, 16'hFFFF, "sm1x1");
        op(1'b0, 8'hFF, 8'h01, 1'b0, 16'h00FF, "u255x1");
        op(1'b0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, "u255x255");

        // Back-pressure: result held, new operands ignored, release returns to IDLE.
        start_op(1'b0, 8'd13, 8'd11, 1'b0);
        wait_done(1'b0, "bp", 8);
        held = m1.result;
        chk("bp_res", held, 16'd143);
        drive(1'b0, 1'b1, 8'd3, 8'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_res", m1.result, 16'd143);
            chk("bp_hold_ov", m1.out_valid, 1'b1);
            chk("bp_hold_ir", m1.in_ready, 1'b0);
        end
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        finish_op(1'b0, "bp");
        tick();
        chk("bp_still_idle", m1.in_ready, 1'b1);

        // Reset asserted for the third CALC edge.
        start_op(1'b0, 8'd100, 8'd100, 1'b0);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        chk("rmid_ov", m1.out_valid, 1'b0);
        chk("rmid_res", m1.result, 16'h0000);
        chk("rmid_ir", m1.in_ready, 1'b1);
        chk("rmid_busy", m1.busy, 1'b0);
        reset_n = 1'b1;
        tick();
        op(1'b0, 8'd7, 8'hFD, 1'b1, 16'hFFEB, "post_rst");

        op(1'b1, 8'hFF, 8'hFF, 1'b0, 16'hFE01, "s4_u255x255");
        op(1'b1, 8'h80, 8'h7F, 1'b1, 16'hC080, "s4_sm128x127");

        for (int i = 0; i < 200; i++) rand_op(1'b0, "rnd1");
        for (int i = 0; i < 10000; i++) rand_op(1'b1, "rnd4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
